// File: rtl/offchip_link_pkg.sv
// Shared definitions for the off-chip 16-bit lane link (receive and transmit sides).
package offchip_link_pkg;

  localparam int LANE_W         = 16;
  localparam int BEATS_PER_WORD = 4;
  localparam int DATA_W         = LANE_W * BEATS_PER_WORD;

  typedef enum logic [1:0] {
    ASM_A0 = 2'd0,
    ASM_A1 = 2'd1,
    ASM_A2 = 2'd2,
    ASM_A3 = 2'd3
  } asm_state_e;

  // Beat k carries byte k in its low half and byte k+4 in its high half.
  function automatic logic [LANE_W-1:0] beat_slice(input logic [DATA_W-1:0] word,
                                                   input int unsigned k);
    return {word[8*k+32 +: 8], word[8*k +: 8]};
  endfunction

  // Inverse of beat_slice over a full set of four beats.
  function automatic logic [DATA_W-1:0] beats_to_word(input logic [LANE_W-1:0] b0,
                                                      input logic [LANE_W-1:0] b1,
                                                      input logic [LANE_W-1:0] b2,
                                                      input logic [LANE_W-1:0] b3);
    return {b3[15:8], b2[15:8], b1[15:8], b0[15:8],
            b3[7:0],  b2[7:0],  b1[7:0],  b0[7:0]};
  endfunction

endpackage

// File: rtl/offchip_rx_fifo.sv
// Word buffer for the lane receiver: DEPTH x WIDTH storage, wrap-bit pointers.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module offchip_rx_fifo
  import offchip_link_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = DATA_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update; reset empties the buffer.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write; contents are don't-care until pushed.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/offchip_link_rx.sv
// Receive end of the off-chip lane link: beat assembly, word FIFO, output register,
// credit return. Optional lane parity checking is enabled by OFFCHIP_RX_PARITY_EN.
//
// state  | meaning
// A0     | waiting for beat 0 (lane_sof must be set)
// A1     | beat 0 stored, waiting for beat 1
// A2     | beats 0-1 stored, waiting for beat 2
// A3     | beats 0-2 stored, next beat completes the word
module offchip_link_rx
  import offchip_link_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [LANE_W-1:0] i_lane_in,
  input  logic              i_lane_valid,
  input  logic              i_lane_sof,
`ifdef OFFCHIP_RX_PARITY_EN
  input  logic              i_lane_par,
  output logic              o_data_err,
`endif
  output logic              o_credit_ret,
  output logic [DATA_W-1:0] o_data_out,
  output logic              o_valid_out,
  input  logic              i_ready,
  output logic              o_frame_err,
  output logic              o_overflow_err
);

`ifdef OFFCHIP_RX_PARITY_EN
  localparam int FIFO_W = DATA_W + 1;
`else
  localparam int FIFO_W = DATA_W;
`endif

  asm_state_e        r_state;
  asm_state_e        w_state_nxt;
  logic              w_ld0, w_ld1, w_ld2;
  logic              w_push;
  logic              w_ferr_set;
  logic [LANE_W-1:0] r_beat0, r_beat1, r_beat2;
  logic [DATA_W-1:0] w_word;
  logic [FIFO_W-1:0] w_fifo_din;
  logic [FIFO_W-1:0] w_fifo_dout;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic              w_pop;
  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic              r_frame_err;
  logic              r_overflow_err;

  // Assembly state register.
  always_ff @(posedge i_clk) begin
    if (!i_rst) r_state <= ASM_A0;
    else        r_state <= w_state_nxt;
  end

  // Next state and beat capture strobes; a stray sof restarts the word at this beat.
  always_comb begin
    w_state_nxt = r_state;
    w_ld0       = 1'b0;
    w_ld1       = 1'b0;
    w_ld2       = 1'b0;
    w_push      = 1'b0;
    w_ferr_set  = 1'b0;
    if (i_lane_valid) begin
      if (r_state == ASM_A0) begin
        if (i_lane_sof) begin
          w_ld0       = 1'b1;
          w_state_nxt = ASM_A1;
        end else begin
          w_ferr_set  = 1'b1;
        end
      end else if (i_lane_sof) begin
        w_ferr_set  = 1'b1;
        w_ld0       = 1'b1;
        w_state_nxt = ASM_A1;
      end else begin
        case (r_state)
          ASM_A1: begin w_ld1 = 1'b1; w_state_nxt = ASM_A2; end
          ASM_A2: begin w_ld2 = 1'b1; w_state_nxt = ASM_A3; end
          ASM_A3: begin w_push = 1'b1; w_state_nxt = ASM_A0; end
          default: w_state_nxt = ASM_A0;
        endcase
      end
    end
  end

  // Beat holding registers for the word under assembly.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_beat0 <= '0;
      r_beat1 <= '0;
      r_beat2 <= '0;
    end else begin
      if (w_ld0) r_beat0 <= i_lane_in;
      if (w_ld1) r_beat1 <= i_lane_in;
      if (w_ld2) r_beat2 <= i_lane_in;
    end
  end

  assign w_word = beats_to_word(r_beat0, r_beat1, r_beat2, i_lane_in);

`ifdef OFFCHIP_RX_PARITY_EN
  logic w_beat_bad;
  logic r_par_acc;
  logic r_data_err;

  // Odd parity: lane_in plus lane_par must carry an odd number of ones.
  assign w_beat_bad = ~^{i_lane_in, i_lane_par};
  assign w_fifo_din = {r_par_acc | w_beat_bad, w_word};

  // Accumulate parity failures over the beats of the current word.
  always_ff @(posedge i_clk) begin
    if (!i_rst)             r_par_acc <= 1'b0;
    else if (w_ld0)         r_par_acc <= w_beat_bad;
    else if (w_ld1 | w_ld2) r_par_acc <= r_par_acc | w_beat_bad;
  end

  // Word mark travels alongside the output register.
  always_ff @(posedge i_clk) begin
    if (!i_rst)     r_data_err <= 1'b0;
    else if (w_pop) r_data_err <= w_fifo_dout[DATA_W];
  end

  assign o_data_err = r_data_err & r_valid;
`else
  assign w_fifo_din = w_word;
`endif

  offchip_rx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FIFO_W)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_data  (w_fifo_din),
    .i_pop   (w_pop),
    .o_data  (w_fifo_dout),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // Loading the output register frees a FIFO slot, which is what returns a credit.
  assign w_pop = i_rst && !w_fifo_empty && (!r_valid || i_ready);

  // Output register: load on pop, hold under backpressure, drop after handshake.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (w_pop) begin
      r_valid <= 1'b1;
      r_data  <= w_fifo_dout[DATA_W-1:0];
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_frame_err    <= 1'b0;
      r_overflow_err <= 1'b0;
    end else begin
      if (w_ferr_set)                         r_frame_err    <= 1'b1;
      if (w_push && w_fifo_full && !w_pop)    r_overflow_err <= 1'b1;
    end
  end

  assign o_credit_ret   = w_pop;
  assign o_valid_out    = r_valid;
  assign o_data_out     = r_data;
  assign o_frame_err    = r_frame_err;
  assign o_overflow_err = r_overflow_err;

endmodule

// File: tb/tb_offchip_link_rx.sv
// Bench for offchip_link_rx: directed lane traffic, a word-level reference model
// checked every cycle, plus literal expectations for latency, data and flags.
module tb_offchip_link_rx;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] lane_in = '0;
  logic        lane_valid = 1'b0;
  logic        lane_sof = 1'b0;
  logic        ready = 1'b0;
  logic        credit_ret;
  logic [63:0] data_out;
  logic        valid_out;
  logic        frame_err;
  logic        overflow_err;
`ifdef OFFCHIP_RX_PARITY_EN
  logic        lane_par = 1'b1;
  logic        data_err;
`endif

  int n_pass = 0;
  int n_total = 0;
  int credit_cnt = 0;
  int n_deliv = 0;
  logic [63:0] last_w = '0;
  logic        last_e = 1'b0;

  typedef struct {
    logic [63:0] w;
    logic        e;
  } exp_t;
  exp_t        exp_q[$];
  logic [15:0] m_beats[$];
  logic        m_bad = 1'b0;
  logic        m_ferr = 1'b0;
  logic        m_ovf = 1'b0;

  always #5 clk = ~clk;

  offchip_link_rx #(.DEPTH(DEPTH)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_lane_in      (lane_in),
    .i_lane_valid   (lane_valid),
    .i_lane_sof     (lane_sof),
`ifdef OFFCHIP_RX_PARITY_EN
    .i_lane_par     (lane_par),
    .o_data_err     (data_err),
`endif
    .o_credit_ret   (credit_ret),
    .o_data_out     (data_out),
    .o_valid_out    (valid_out),
    .i_ready        (ready),
    .o_frame_err    (frame_err),
    .o_overflow_err (overflow_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Model: word-level rules on the beat stream; byte k from low half, byte k+4 from high half.
  function automatic logic [63:0] model_word(input logic [15:0] b [$]);
    logic [63:0] w = '0;
    for (int k = 0; k < 4; k++) begin
      w[8*k +: 8]     = b[k][7:0];
      w[8*(k+4) +: 8] = b[k][15:8];
    end
    return w;
  endfunction

  // Model update at each active edge, compare against the DUT half a cycle later.
  initial begin
    logic bad;
    forever begin
      @(posedge clk);
      bad = 1'b0;
`ifdef OFFCHIP_RX_PARITY_EN
      bad = ~^{lane_in, lane_par};
`endif
      if (!rst) begin
        m_beats.delete();
        exp_q.delete();
        m_ferr = 1'b0;
        m_ovf  = 1'b0;
      end else if (lane_valid) begin
        if (lane_sof) begin
          if (m_beats.size() != 0) m_ferr = 1'b1;
          m_beats.delete();
          m_beats.push_back(lane_in);
          m_bad = bad;
        end else if (m_beats.size() == 0) begin
          m_ferr = 1'b1;
        end else begin
          m_beats.push_back(lane_in);
          m_bad = m_bad | bad;
          if (m_beats.size() == 4) begin
            if (exp_q.size() >= DEPTH + 1) m_ovf = 1'b1;
            else exp_q.push_back('{w: model_word(m_beats), e: m_bad});
            m_beats.delete();
          end
        end
      end

      @(negedge clk);
      if (credit_ret) credit_cnt++;
      if (valid_out) begin
        if (exp_q.size() == 0) begin
          chk("valid_without_expected_word", 1'b1, 1'b0);
        end else begin
          chk("data_out", data_out, exp_q[0].w);
`ifdef OFFCHIP_RX_PARITY_EN
          chk("data_err", data_err, exp_q[0].e);
`endif
          if (ready) begin
            last_w = data_out;
            last_e = exp_q[0].e;
            exp_q.pop_front();
            n_deliv++;
          end
        end
      end
`ifdef OFFCHIP_RX_PARITY_EN
      else chk("data_err_idle", data_err, 1'b0);
`endif
      chk("frame_err", frame_err, m_ferr);
      chk("overflow_err", overflow_err, m_ovf);
    end
  end

  task automatic beat(input logic [15:0] d, input logic sof, input logic bad = 1'b0);
    @(posedge clk); #1;
    lane_valid = 1'b1;
    lane_in    = d;
    lane_sof   = sof;
`ifdef OFFCHIP_RX_PARITY_EN
    lane_par   = ~(^d) ^ bad;
`else
    if (bad) lane_in = d;
`endif
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      lane_valid = 1'b0;
      lane_sof   = 1'b0;
    end
  endtask

  task automatic send_word(input logic [63:0] w, input logic bad2 = 1'b0);
    logic [15:0] b;
    for (int k = 0; k < 4; k++) begin
      b = {w[8*k+32 +: 8], w[8*k +: 8]};
      beat(b, k == 0, (k == 2) && bad2);
    end
  endtask

  initial begin
    int c0, d0;

    // Reset held for 2 cycles with lane traffic running.
    beat(16'h67EF, 1'b1);
    beat(16'h45CD, 1'b0);
    @(negedge clk);
    chk("rst_valid_out", valid_out, 1'b0);
    chk("rst_data_out", data_out, 64'h0);
    chk("rst_credit_ret", credit_ret, 1'b0);
    chk("rst_frame_err", frame_err, 1'b0);
    chk("rst_overflow_err", overflow_err, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    lane_valid = 1'b0;
    idle(5);
    chk("no_credit_after_rst", credit_cnt, 0);
    chk("no_valid_after_rst", valid_out, 1'b0);

    // Single word, latency and literal data.
    ready = 1'b1;
    beat(16'h67EF, 1'b1);
    beat(16'h45CD, 1'b0);
    beat(16'h23AB, 1'b0);
    beat(16'h0189, 1'b0);
    @(negedge clk);
    chk("lat_credit_N", credit_ret, 1'b0);
    idle(1);
    @(negedge clk);
    chk("lat_credit_N1", credit_ret, 1'b1);
    chk("lat_valid_N1", valid_out, 1'b0);
    @(negedge clk);
    chk("lat_valid_N2", valid_out, 1'b1);
    chk("single_word_data", data_out, 64'h0123456789ABCDEF);
    @(negedge clk);
    chk("single_word_one_cycle", valid_out, 1'b0);
    chk("single_word_credits", credit_cnt, 1);

    // Backpressure: 10 words into a capacity of 9.
    @(posedge clk); #1;
    ready = 1'b0;
    c0 = credit_cnt;
    d0 = n_deliv;
    for (int i = 0; i < 10; i++)
      send_word({32'hA5A5_0000 + 32'(i), 32'h5A5A_1000 + 32'(i)});
    idle(6);
    chk("bp_credits_held", credit_cnt - c0, 1);
    chk("bp_overflow_set", overflow_err, 1'b1);
    chk("bp_no_frame_err", frame_err, 1'b0);
    ready = 1'b1;
    idle(15);
    chk("bp_credits_drained", credit_cnt - c0, 9);
    chk("bp_words_delivered", n_deliv - d0, 9);
    chk("bp_last_word", last_w, 64'hA5A5_0008_5A5A_1008);

    // Framing: sof on the third beat restarts the word there.
    d0 = n_deliv;
    beat(16'h1111, 1'b1);
    beat(16'h2222, 1'b0);
    beat(16'h9810, 1'b1);
    beat(16'hBA32, 1'b0);
    beat(16'hDC54, 1'b0);
    beat(16'hFE76, 1'b0);
    idle(5);
    chk("frame_err_set", frame_err, 1'b1);
    chk("frame_words", n_deliv - d0, 1);
    chk("frame_word", last_w, 64'hFEDCBA9876543210);

    // Reset after beat 1, then a fresh word.
    beat(16'h67EF, 1'b1);
    beat(16'h45CD, 1'b0);
    @(posedge clk); #1;
    lane_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_frame_cleared", frame_err, 1'b0);
    chk("midrst_ovf_cleared", overflow_err, 1'b0);
    chk("midrst_no_valid", valid_out, 1'b0);
    d0 = n_deliv;
    send_word(64'h0F1E2D3C4B5A6978);
    idle(5);
    chk("midrst_words", n_deliv - d0, 1);
    chk("midrst_word", last_w, 64'h0F1E2D3C4B5A6978);
    chk("midrst_no_frame_err", frame_err, 1'b0);

`ifdef OFFCHIP_RX_PARITY_EN
    // Parity error on beat 2 marks the word; the next word is clean.
    send_word(64'h1122334455667788, 1'b1);
    idle(5);
    chk("par_bad_word", last_w, 64'h1122334455667788);
    chk("par_bad_mark", last_e, 1'b1);
    send_word(64'h8877665544332211);
    idle(5);
    chk("par_clean_word", last_w, 64'h8877665544332211);
    chk("par_clean_mark", last_e, 1'b0);
`endif

    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
